// File: rtl/fk_pipe.sv
// fk_pipe: two-stage pipelined S-DES round function (Fk) with valid/ready
// handshakes on both sides.
// Stage 1 registers the E/P-expanded right nibble XORed with the subkey.
// Stage 2 runs the S-boxes and P4, then registers the round result.
// Build option: define FK_SWAP_EN to fold the SW half swap into the output
// ({R, L ^ p4} instead of {L ^ p4, R}).

// S0 lookup: row = {in[3], in[0]}, column = {in[2], in[1]}.
module fk_sbox0 (
    input  logic [3:0] sbox_in,
    output logic [1:0] sbox_out
);
    // Table lookup indexed as {row, column}.
    always_comb begin
        unique case ({sbox_in[3], sbox_in[0], sbox_in[2], sbox_in[1]})
            4'd0:  sbox_out = 2'd1;  4'd1:  sbox_out = 2'd0;
            4'd2:  sbox_out = 2'd3;  4'd3:  sbox_out = 2'd2;
            4'd4:  sbox_out = 2'd3;  4'd5:  sbox_out = 2'd2;
            4'd6:  sbox_out = 2'd1;  4'd7:  sbox_out = 2'd0;
            4'd8:  sbox_out = 2'd0;  4'd9:  sbox_out = 2'd2;
            4'd10: sbox_out = 2'd1;  4'd11: sbox_out = 2'd3;
            4'd12: sbox_out = 2'd3;  4'd13: sbox_out = 2'd1;
            4'd14: sbox_out = 2'd3;  default: sbox_out = 2'd2;
        endcase
    end
endmodule

// S1 lookup: row = {in[3], in[0]}, column = {in[2], in[1]}.
module fk_sbox1 (
    input  logic [3:0] sbox_in,
    output logic [1:0] sbox_out
);
    // Table lookup indexed as {row, column}.
    always_comb begin
        unique case ({sbox_in[3], sbox_in[0], sbox_in[2], sbox_in[1]})
            4'd0:  sbox_out = 2'd0;  4'd1:  sbox_out = 2'd1;
            4'd2:  sbox_out = 2'd2;  4'd3:  sbox_out = 2'd3;
            4'd4:  sbox_out = 2'd2;  4'd5:  sbox_out = 2'd0;
            4'd6:  sbox_out = 2'd1;  4'd7:  sbox_out = 2'd3;
            4'd8:  sbox_out = 2'd3;  4'd9:  sbox_out = 2'd0;
            4'd10: sbox_out = 2'd1;  4'd11: sbox_out = 2'd0;
            4'd12: sbox_out = 2'd2;  4'd13: sbox_out = 2'd1;
            4'd14: sbox_out = 2'd0;  default: sbox_out = 2'd3;
        endcase
    end
endmodule

module fk_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] data_in,
    input  logic [7:0] subkey,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] data_out,
    output logic       busy
);
    logic       s1_valid_q, s1_valid_d;
    logic [7:0] x_q, x_d;
    logic [3:0] l_q, l_d;
    logic [3:0] r_q, r_d;
    logic       s2_valid_q, s2_valid_d;
    logic [7:0] data_out_q, data_out_d;

    logic       adv1, adv2;
    logic [3:0] r_in;
    logic [7:0] ep;
    logic [1:0] s0, s1;
    logic [3:0] p4;
    logic [3:0] l_new;

    assign adv2 = !s2_valid_q || out_ready;
    assign adv1 = !s1_valid_q || adv2;

    assign r_in = data_in[3:0];
    // r1 is R[3], r4 is R[0]: ep = {r4, r1, r2, r3, r2, r3, r4, r1}.
    assign ep = {r_in[0], r_in[3], r_in[2], r_in[1], r_in[2], r_in[1], r_in[0], r_in[3]};

    fk_sbox0 u_sbox0 (.sbox_in(x_q[7:4]), .sbox_out(s0));
    fk_sbox1 u_sbox1 (.sbox_in(x_q[3:0]), .sbox_out(s1));

    // b = {s0[1], s0[0], s1[1], s1[0]}, p4 = {b2, b4, b3, b1}.
    assign p4    = {s0[0], s1[0], s1[1], s0[1]};
    assign l_new = l_q ^ p4;

    // Next-state for both stages; data only loads on a real transfer so the
    // registers keep their reset zeros until a valid word arrives.
    always_comb begin
        s1_valid_d = s1_valid_q;
        x_d        = x_q;
        l_d        = l_q;
        r_d        = r_q;
        s2_valid_d = s2_valid_q;
        data_out_d = data_out_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                x_d = ep ^ subkey;
                l_d = data_in[7:4];
                r_d = r_in;
            end
        end
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
`ifdef FK_SWAP_EN
                data_out_d = {r_q, l_new};
`else
                data_out_d = {l_new, r_q};
`endif
            end
        end
    end

    // Pipeline registers with synchronous reset; reset drops in-flight words.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            x_q        <= 8'h00;
            l_q        <= 4'h0;
            r_q        <= 4'h0;
            s2_valid_q <= 1'b0;
            data_out_q <= 8'h00;
        end else begin
            s1_valid_q <= s1_valid_d;
            x_q        <= x_d;
            l_q        <= l_d;
            r_q        <= r_d;
            s2_valid_q <= s2_valid_d;
            data_out_q <= data_out_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = s2_valid_q;
    assign data_out  = data_out_q;
    assign busy      = s1_valid_q | s2_valid_q;
endmodule

// File: tb/tb_fk_pipe.sv
// Scoreboard bench for fk_pipe: the driver records the expected result of
// every accepted word, a monitor pops and compares on each output transfer.
module tb_fk_pipe;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_in;
    logic [7:0] subkey;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data_out;
    logic       busy;

    logic [7:0] exp_in;
    logic [7:0] sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_push = 0;
    int         n_pop = 0;
    int         n_drop = 0;
    bit         rand_rdy = 0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    always #5 clk = ~clk;

    fk_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .subkey(subkey),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .busy(busy)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] sbox(input int which, input logic [3:0] v);
        logic [1:0] t0 [4][4];
        logic [1:0] t1 [4][4];
        int row, col;
        t0 = '{'{2'd1, 2'd0, 2'd3, 2'd2}, '{2'd3, 2'd2, 2'd1, 2'd0},
               '{2'd0, 2'd2, 2'd1, 2'd3}, '{2'd3, 2'd1, 2'd3, 2'd2}};
        t1 = '{'{2'd0, 2'd1, 2'd2, 2'd3}, '{2'd2, 2'd0, 2'd1, 2'd3},
               '{2'd3, 2'd0, 2'd1, 2'd0}, '{2'd2, 2'd1, 2'd0, 2'd3}};
        row = 2 * int'(v[3]) + int'(v[0]);
        col = 2 * int'(v[2]) + int'(v[1]);
        return (which == 0) ? t0[row][col] : t1[row][col];
    endfunction

    // Reference Fk using S-DES 1-based bit numbering (bit 1 = MSB).
    function automatic logic [7:0] fk_ref(input logic [7:0] d, input logic [7:0] k);
        logic [3:0] l, r, p4, b;
        logic [7:0] ep, x;
        l = d[7:4];
        r = d[3:0];
        ep = {r[4-4], r[4-1], r[4-2], r[4-3], r[4-2], r[4-3], r[4-4], r[4-1]};
        x = ep ^ k;
        b = {sbox(0, x[7:4]), sbox(1, x[3:0])};
        p4 = {b[4-2], b[4-4], b[4-3], b[4-1]};
`ifdef FK_SWAP_EN
        return {r, l ^ p4};
`else
        return {l ^ p4, r};
`endif
    endfunction

    // Acceptor and monitor: sample at negedge, transfers happen at the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                sb.push_back(exp_in);
                n_push++;
            end
            if (hold_v && out_valid)
                check("hold_stable", data_out, hold_d);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", data_out, 8'hxx);
                end else begin
                    check("sb_data", data_out, sb.pop_front());
                    n_pop++;
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = data_out;
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Presents one word and returns 1 ns after the edge that accepted it.
    task automatic send(input logic [7:0] d, input logic [7:0] k, input logic [7:0] e);
        bit ok;
        data_in  = d;
        subkey   = k;
        exp_in   = e;
        in_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            step();
        end
        if (!ok) check("send_timeout", 8'h00, 8'h01);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int t = 0; t < 500 && !done; t++) begin
            step();
            done = !busy && !rand_rdy;
            if (rand_rdy && !busy) done = 1;
        end
        if (!done) check("drain_timeout", 8'h00, 8'h01);
    endtask

    logic [7:0] e_a, e_b, e_c, snap;
    logic [7:0] keys [3];

    initial begin
`ifdef FK_SWAP_EN
        e_a = 8'h08; e_b = 8'hF7; e_c = 8'hF8;
`else
        e_a = 8'h80; e_b = 8'h7F; e_c = 8'h8F;
`endif
        keys = '{8'h00, 8'hA5, 8'hFF};
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        data_in = 8'h5A; subkey = 8'h3C; exp_in = 8'h00;

        // Reset with in_valid high.
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check("rst_out_valid", {7'd0, out_valid}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_data_out", data_out, 8'h00);
        check("rst_in_ready", {7'd0, in_ready}, 8'h01);
        step(); step();
        check("rst_no_output", {7'd0, out_valid}, 8'h00);

        // Single vectors, result visible two edges after presenting.
        send(8'h00, 8'h00, e_a); in_valid = 1'b0;
        check("single_lat_a", {7'd0, out_valid}, 8'h00);
        step();
        check("single_valid_a", {7'd0, out_valid}, 8'h01);
        check("single_data_a", data_out, e_a);
        step();
        send(8'h0F, 8'h00, e_b); in_valid = 1'b0; step();
        check("single_data_b", data_out, e_b);
        step();
        send(8'h0F, 8'hFF, e_c); in_valid = 1'b0; step();
        check("single_data_c", data_out, e_c);
        step(); step();

        // Streaming: back-to-back accepts, back-to-back outputs.
        send(8'h00, 8'h00, e_a);
        check("stream_v0", {7'd0, out_valid}, 8'h00);
        send(8'h0F, 8'h00, e_b);
        check("stream_v1", {7'd0, out_valid}, 8'h01);
        send(8'h0F, 8'hFF, e_c);
        check("stream_v2", {7'd0, out_valid}, 8'h01);
        in_valid = 1'b0; step();
        check("stream_v3", {7'd0, out_valid}, 8'h01);
        step();
        check("stream_v4", {7'd0, out_valid}, 8'h00);

        // Backpressure: two words fill the pipe, third waits.
        out_ready = 1'b0;
        send(8'h0F, 8'h00, e_b);
        send(8'h00, 8'h00, e_a);
        data_in = 8'h0F; subkey = 8'hFF; exp_in = e_c;
        check("bp_in_ready_low", {7'd0, in_ready}, 8'h00);
        snap = data_out;
        check("bp_head", snap, e_b);
        step(); step(); step();
        check("bp_stable", data_out, snap);
        check("bp_in_ready_still_low", {7'd0, in_ready}, 8'h00);
        out_ready = 1'b1;
        send(8'h0F, 8'hFF, e_c);
        in_valid = 1'b0;
        drain();

        // Reset mid-flight with both stages valid.
        out_ready = 1'b0;
        send(8'h11, 8'h22, fk_ref(8'h11, 8'h22));
        send(8'h33, 8'h44, fk_ref(8'h33, 8'h44));
        in_valid = 1'b0;
        check("mid_busy", {7'd0, busy}, 8'h01);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_drop += sb.size();
        sb.delete();
        check("mid_out_valid", {7'd0, out_valid}, 8'h00);
        check("mid_busy_clear", {7'd0, busy}, 8'h00);
        check("mid_data_out", data_out, 8'h00);
        out_ready = 1'b1;
        step(); step(); step();
        check("mid_no_ghost", {7'd0, out_valid}, 8'h00);

        // Exhaustive sweep with random downstream readiness.
        rand_rdy = 1;
        foreach (keys[j])
            for (int i = 0; i < 256; i++)
                send(8'(i), keys[j], fk_ref(8'(i), keys[j]));
        in_valid = 1'b0;
        drain();
        rand_rdy = 0;
        out_ready = 1'b1;
        step(); step();
        check("final_idle", {7'd0, busy}, 8'h00);
        n_cmp++;
        if (n_pop != n_push - n_drop) begin
            n_bad++;
            $display("FAIL count_words: got %0d outputs expected %0d", n_pop, n_push - n_drop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fk_pipe.md
# fk_pipe

Two-stage pipelined S-DES round function (Fk) with valid/ready handshakes on both sides. It takes an 8-bit half-round word and an 8-bit subkey, then performs these steps:

- expansion/permutation (E/P) of the right nibble;
- XOR with the subkey;
- drives the existing S0 and S1 S-box modules;
- applies P4 and XORs the result into the left nibble.

It sits between the initial-permutation/round-control logic and the next round or the final permutation.

## Interface
Parameters:
- none (S-DES widths are fixed).

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `data_in`/`subkey` valid this cycle.
- `in_ready` output 1: block accepts input this cycle.
- `data_in` input 8: `{L, R}`; `data_in[7]` is S-DES bit 1.
- `subkey` input 8: K1 or K2; `subkey[7]` is S-DES bit 1; sampled with `data_in`.
- `out_valid` output 1: `data_out` holds a result.
- `out_ready` input 1: downstream accepts result.
- `data_out` output 8: Fk result; see Configuration for ordering.
- `busy` output 1: any pipeline stage holds a valid word.

## Operation
Naming and the input transfer:
- Let `L = data_in[7:4]` and `R = data_in[3:0]`, with `r1 = R[3]` … `r4 = R[0]`.
- An input transfer happens when `in_valid && in_ready`.

Stage 1 (capture register):
- `ep = {r4, r1, r2, r3, r2, r3, r4, r1}`.
- `x = ep ^ subkey`.
- Registers `x`, `L`, `R` and `s1_valid`.

Stage 2 (combinational into the output register):
- `S0.leftSide = x[7:4]` gives `s0[1:0]`.
- The S1 instance takes `x[3:0]` and gives `s1[1:0]`.
- S-box indexing: row = outer bits `{in[3], in[0]}`, column = inner bits `{in[2], in[1]}`.
- S1 table, rows 0–3: `0 1 2 3` / `2 0 1 3` / `3 0 1 0` / `2 1 0 3`.
- Let `b = {s0[1], s0[0], s1[1], s1[0]}` (b1..b4). Then `p4 = {b2, b4, b3, b1}`.
- Result: `{L ^ p4, R}`, registered with `s2_valid`.

Flow control:
- `adv2 = !s2_valid || out_ready`.
- `adv1 = !s1_valid || adv2`.
- `in_ready = adv1`.
- When `adv2` is high: stage 2 loads from stage 1 and `s2_valid <= s1_valid`.
- When `adv1` is high: stage 1 loads input and `s1_valid <= in_valid`.
- Output mapping: `out_valid = s2_valid`, `busy = s1_valid | s2_valid`.

Boundary conditions:
- **Stall:** while `out_valid && !out_ready`, `data_out` and stage 2 hold stable. Stage 1 holds if valid; otherwise it can absorb one more word. After that, `in_ready` is low.
- **Simultaneous accept and output:** full throughput, one word per cycle, with no bubble.
- **Reset mid-operation:** in-flight words are discarded with no partial output.
- **Data registers when invalid:** they do not matter, but must not be X-propagating into `data_out` after reset.

## Timing
Reset values:
- `s1_valid = 0`, `s2_valid = 0`.
- All data registers are 0.
- `out_valid = 0`, `busy = 0`, `data_out = 8'h00`.
- `in_ready = 1` in the first cycle after reset.

Latency and throughput:
- Latency: input accepted at edge N, `out_valid` high after edge N+1 (2-register pipeline).
- Throughput: 1 word/cycle while `out_ready = 1`.

Handshake rules:
- `in_ready` depends combinationally on `out_ready`; there is no combinational path from `in_valid` to any output.
- Once `out_valid` rises, `data_out` is held unchanged until the transfer.

## Configuration
- `FK_SWAP_EN` defined: `data_out = {R, L ^ p4}`, i.e. the SW halves swap is folded into the block for round 1 use.
- `FK_SWAP_EN` undefined (default): `data_out = {L ^ p4, R}`.
- No other behaviour changes.

## Test plan
- **Reset:** reset asserted for 2 cycles with `in_valid = 1` → `out_valid = 0`, `busy = 0`, `data_out = 8'h00`, `in_ready = 1`. No output appears until the first post-reset accept.
- **Single vectors**, each observed 2 cycles after accept:

  | `data_in` | `subkey` | `data_out` | `data_out` with `FK_SWAP_EN` |
  |---|---|---|---|
  | `8'h00` | `8'h00` | `8'h80` | `8'h08` |
  | `8'h0F` | `8'h00` | `8'h7F` | `8'hF7` |
  | `8'h0F` | `8'hFF` | `8'h8F` | `8'hF8` |

- **Streaming:** the three vectors above on consecutive cycles with `out_ready = 1` → outputs on 3 consecutive cycles, in order, with no bubbles.
- **Backpressure:** `out_ready = 0` while streaming → `in_ready` drops after 2 accepted words and `data_out` stays stable. Raising `out_ready` drains in order with no loss or duplication.
- **Reset mid-flight:** reset with both stages valid → next cycle `out_valid = 0` and `busy = 0`; the dropped words never appear.
- **Exhaustive check:** all 256 `data_in` values × subkeys `8'h00`, `8'hA5`, `8'hFF` against a reference model, including random `out_ready` toggling.
